// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg : shared definitions for the Y86 memory stage.
//   - icode constants for the instructions that touch data memory
//   - state_t : memory-stage FSM states
//   - helper functions that classify an icode (access / read / write /
//     address taken from valA)
// No ports; imported by mem_stage.
// ---------------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Reads pull a quadword from memory into valM
  function automatic logic isRead(input logic [3:0] ic);
    return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
  endfunction

  // Writes push a quadword (valA, or valP for call) into memory
  function automatic logic isWrite(input logic [3:0] ic);
    return (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
  endfunction

  function automatic logic isAccess(input logic [3:0] ic);
    return isRead(ic) || isWrite(ic);
  endfunction

  // ret and popq address memory through the stack pointer carried in valA
  function automatic logic addrFromValA(input logic [3:0] ic);
    return (ic == I_RET) || (ic == I_POPQ);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if : request/response bundle between the pipeline and mem_stage.
//   master (pipeline) drives : start, icode, valE, valA, valP
//   slave  (mem_stage) drives: busy, done, valM, dmem_error
// ---------------------------------------------------------------------------
interface mem_stage_if #(
  parameter int ADDR_W = 64
);

  logic              start;
  logic [3:0]        icode;
  logic [ADDR_W-1:0] valE;
  logic [ADDR_W-1:0] valA;
  logic [63:0]       valP;
  logic              busy;
  logic              done;
  logic [63:0]       valM;
  logic              dmem_error;

  modport master (
    output start, icode, valE, valA, valP,
    input  busy, done, valM, dmem_error
  );

  modport slave (
    input  start, icode, valE, valA, valP,
    output busy, done, valM, dmem_error
  );

endinterface

// File: rtl/mem_stage_dmem_bytes.sv
// ---------------------------------------------------------------------------
// dmem_bytes : single-port, byte-wide synchronous data RAM.
//   i_clk   : clock
//   i_we    : write enable, writes i_wdata at i_addr on the clock edge
//   i_addr  : byte address
//   i_wdata : write byte
//   o_rdata : byte at the address presented in the previous cycle
// Contents are not touched by any reset.
// ---------------------------------------------------------------------------
module dmem_bytes #(
  parameter int MEM_BYTES = 1024,
  parameter int IDX_W     = $clog2(MEM_BYTES)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_addr,
  input  logic [7:0]       i_wdata,
  output logic [7:0]       o_rdata
);

  logic [7:0] r_mem [MEM_BYTES];
  logic [7:0] r_rdata;

  // Registered read port plus write port sharing the one address
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage : Y86 memory stage moving one 8-byte little-endian quadword
// through a byte-wide RAM, one byte per cycle.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : mem_stage_if.slave (start/icode/valE/valA/valP in,
//         busy/done/valM/dmem_error out)
// ---------------------------------------------------------------------------
import y86_pkg::*;

module mem_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  localparam int                IDX_W      = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_LEGAL = ADDR_W'(MEM_BYTES - 8);

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_icode;
  logic [IDX_W-1:0]  r_base;
  logic [63:0]       r_wdata;
  logic [2:0]        r_count;
  logic [55:0]       r_asm;
  logic [63:0]       r_valM;
  logic              r_err;

  logic [ADDR_W-1:0] w_addrSel;
  logic              w_access;
  logic              w_rangeErr;
  logic              w_isWrite;
  logic              w_ramWe;
  logic [IDX_W-1:0]  w_ramAddr;
  logic [7:0]        w_wbyte;
  logic [7:0]        w_rdata;

  assign w_addrSel  = addrFromValA(bus.icode) ? bus.valA : bus.valE;
  assign w_access   = isAccess(bus.icode);
  // A plain unsigned compare also catches addresses whose addr+7 would wrap
  assign w_rangeErr = (w_addrSel > LAST_LEGAL);
  assign w_isWrite  = isWrite(r_icode);
  assign w_ramWe    = (r_state == ACCESS) && w_isWrite;
  assign w_wbyte    = r_wdata[{r_count, 3'b000} +: 8];

  // RAM address: writes use byte r_count directly. Reads run one byte ahead
  // (the base is presented while still IDLE) so that byte i comes out of the
  // registered RAM during the (i+1)th ACCESS cycle, and byte 7 is on o_rdata
  // in the last ACCESS cycle, ready to complete valM on the move to DONE.
  always_comb begin
    w_ramAddr = w_addrSel[IDX_W-1:0];
    if (r_state == ACCESS) begin
      if (w_isWrite) begin
        w_ramAddr = r_base + IDX_W'(r_count);
      end else begin
        w_ramAddr = r_base + IDX_W'(r_count) + IDX_W'(1);
      end
    end
  end

  dmem_bytes #(
    .MEM_BYTES (MEM_BYTES),
    .IDX_W     (IDX_W)
  ) u_dmem (
    .i_clk   (clk),
    .i_we    (w_ramWe),
    .i_addr  (w_ramAddr),
    .i_wdata (w_wbyte),
    .o_rdata (w_rdata)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and status outputs. Out-of-range or non-memory requests skip
  // ACCESS entirely and complete the cycle after start.
  always_comb begin
    w_nextState = r_state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextState = (w_access && !w_rangeErr) ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        bus.busy = 1'b1;
        if (r_count == 3'd7) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: capture the request on an accepted start, step the byte counter
  // through ACCESS, and assemble read bytes so valM only changes once the
  // whole quadword is known.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_icode <= 4'h0;
      r_base  <= '0;
      r_wdata <= 64'h0;
      r_count <= 3'd0;
      r_asm   <= 56'h0;
      r_valM  <= 64'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_icode <= bus.icode;
            r_base  <= w_addrSel[IDX_W-1:0];
            r_wdata <= (bus.icode == I_CALL) ? bus.valP : 64'(bus.valA);
            r_count <= 3'd0;
            r_err   <= w_access && w_rangeErr;
          end
        end
        ACCESS: begin
          r_count <= r_count + 3'd1;
          if (!w_isWrite) begin
            if (r_count == 3'd7) begin
              r_valM <= {w_rdata, r_asm};
            end else begin
              r_asm[{r_count, 3'b000} +: 8] <= w_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.valM       = r_valM;
  assign bus.dmem_error = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage : self-checking bench for mem_stage.
// Directed table of requests, a reset-abort sequence and a randomized run
// checked against a byte-array reference model of the data memory.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic [63:0] expValM;
    logic        expErr;
    int          expLat;
    bit          midStart;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0]  mMem [1024];
  logic [63:0] mValM;
  logic        mErr;

  vec_t vecs [15];

  mem_stage_if #(.ADDR_W(64)) bus ();

  mem_stage #(
    .MEM_BYTES (1024),
    .ADDR_W    (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the bench itself wedges
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Reference model: applies one request to the byte array and predicts
  // valM, dmem_error and completion latency from the access rules.
  task automatic modelOp(input logic [3:0] ic, input logic [63:0] e,
                         input logic [63:0] a, input logic [63:0] p,
                         output logic [63:0] expM, output logic expE,
                         output int expL);
    bit          acc;
    bit          rd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] q;
    acc  = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
           (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
    rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    addr = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
    mErr = acc && (addr > 64'd1016);
    if (acc && !mErr) begin
      if (rd) begin
        q = 64'h0;
        for (int i = 0; i < 8; i++) begin
          q = q | (64'(mMem[int'(addr) + i]) << (8 * i));
        end
        mValM = q;
      end else begin
        data = (ic == 4'h8) ? p : a;
        for (int i = 0; i < 8; i++) begin
          mMem[int'(addr) + i] = 8'((data >> (8 * i)) & 64'hFF);
        end
      end
      expL = 9;
    end else begin
      expL = 1;
    end
    expM = mValM;
    expE = mErr;
  endtask

  // One request: pulse start, scramble the inputs afterwards, watch for done
  // within a bounded number of edges, then confirm a stray start around the
  // DONE cycle is not accepted.
  task automatic applyStimulus(input string name, input logic [3:0] ic,
                               input logic [63:0] e, input logic [63:0] a,
                               input logic [63:0] p, input logic [63:0] expM,
                               input logic expE, input int expL,
                               input bit midStart);
    int n;
    int busyCnt;
    int lat;
    bus.start = 1'b1;
    bus.icode = ic;
    bus.valE  = e;
    bus.valA  = a;
    bus.valP  = p;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.icode = 4'($urandom);
    bus.valE  = {$urandom, $urandom};
    bus.valA  = {$urandom, $urandom};
    bus.valP  = {$urandom, $urandom};
    n       = 1;
    busyCnt = 0;
    lat     = -1;
    while (n <= 20) begin
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
      bus.start = (midStart && n == 3) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checkOutput({name, " latency"}, 64'(lat), 64'(expL));
    checkOutput({name, " valM"}, bus.valM, expM);
    checkOutput({name, " dmem_error"}, 64'(bus.dmem_error), 64'(expE));
    checkOutput({name, " busy cycles"}, 64'(busyCnt), 64'(expL));
    bus.start = midStart;
    @(posedge clk); #1;
    checkOutput({name, " done after"}, 64'(bus.done), 64'h0);
    bus.start = 1'b0;
    @(posedge clk); #1;
    checkOutput({name, " idle after"}, 64'(bus.busy), 64'h0);
    checkOutput({name, " valM held"}, bus.valM, expM);
  endtask

  initial begin
    logic [63:0] eM;
    logic        eE;
    int          eL;
    logic [3:0]  ic;
    logic [63:0] addr;
    logic [63:0] other;
    logic [63:0] data;
    int          sel;

    checks = 0;
    errors = 0;
    mValM  = 64'h0;
    mErr   = 1'b0;
    for (int i = 0; i < 1024; i++) mMem[i] = 8'h00;

    vecs[0]  = '{4'h4, 64'h10, 64'h0123456789ABCDEF, 64'h0, 64'h0, 1'b0, 9, 1'b0};
    vecs[1]  = '{4'h5, 64'h10, 64'h3F9, 64'h0, 64'h0123456789ABCDEF, 1'b0, 9, 1'b1};
    vecs[2]  = '{4'h5, 64'h11, 64'h0, 64'h0, 64'h000123456789ABCD, 1'b0, 9, 1'b0};
    vecs[3]  = '{4'h5, 64'h17, 64'h0, 64'h0, 64'h0000000000000001, 1'b0, 9, 1'b0};
    vecs[4]  = '{4'h8, 64'h3F8, 64'h5555, 64'h42, 64'h0000000000000001, 1'b0, 9, 1'b0};
    vecs[5]  = '{4'h9, 64'h3FF, 64'h3F8, 64'h0, 64'h42, 1'b0, 9, 1'b0};
    vecs[6]  = '{4'h5, 64'h3F8, 64'h0, 64'h0, 64'h42, 1'b0, 9, 1'b0};
    vecs[7]  = '{4'h5, 64'h3F9, 64'h0, 64'h0, 64'h42, 1'b1, 1, 1'b0};
    vecs[8]  = '{4'h1, 64'h10, 64'h10, 64'h0, 64'h42, 1'b0, 1, 1'b1};
    vecs[9]  = '{4'h5, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 64'h42, 1'b1, 1, 1'b0};
    vecs[10] = '{4'hB, 64'h0, 64'h3FC, 64'h0, 64'h42, 1'b1, 1, 1'b0};
    vecs[11] = '{4'hA, 64'h100, 64'hDEADBEEFCAFEF00D, 64'h0, 64'h42, 1'b0, 9, 1'b1};
    vecs[12] = '{4'hB, 64'h3F9, 64'h100, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 9, 1'b0};
    vecs[13] = '{4'h5, 64'h100, 64'h3F9, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 9, 1'b0};
    vecs[14] = '{4'hF, 64'h3F9, 64'h3F9, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 1, 1'b0};

    // Reset held together with a start request: reset must win
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.icode = 4'h4;
    bus.valE  = 64'h20;
    bus.valA  = 64'hFFFF;
    bus.valP  = 64'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset busy", 64'(bus.busy), 64'h0);
    checkOutput("reset done", 64'(bus.done), 64'h0);
    checkOutput("reset valM", bus.valM, 64'h0);
    checkOutput("reset dmem_error", 64'(bus.dmem_error), 64'h0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    checkOutput("post reset idle", 64'(bus.busy), 64'h0);

    // Clear the whole memory so later reads never see power-up contents
    $display("[TB] clearing memory");
    for (int i = 0; i < 128; i++) begin
      modelOp(4'h4, 64'(i * 8), 64'h0, 64'h0, eM, eE, eL);
      applyStimulus($sformatf("clear%0d", i), 4'h4, 64'(i * 8), 64'h0, 64'h0,
                    eM, eE, eL, 1'b0);
    end

    $display("[TB] directed table");
    for (int i = 0; i < 15; i++) begin
      modelOp(vecs[i].icode, vecs[i].valE, vecs[i].valA, vecs[i].valP, eM, eE, eL);
      applyStimulus($sformatf("vec%0d", i), vecs[i].icode, vecs[i].valE,
                    vecs[i].valA, vecs[i].valP, vecs[i].expValM,
                    vecs[i].expErr, vecs[i].expLat, vecs[i].midStart);
    end

    // Reset abort: a pushq is cut off in its 4th ACCESS cycle
    $display("[TB] reset abort sequence");
    modelOp(4'h4, 64'h200, 64'h1111111111111111, 64'h0, eM, eE, eL);
    applyStimulus("abort prefill", 4'h4, 64'h200, 64'h1111111111111111, 64'h0,
                  eM, eE, eL, 1'b0);
    bus.start = 1'b1;
    bus.icode = 4'hA;
    bus.valE  = 64'h200;
    bus.valA  = 64'h8877665544332211;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("abort no done %0d", k), 64'(bus.done), 64'h0);
      if (k < 4) begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort busy", 64'(bus.busy), 64'h0);
    checkOutput("abort done", 64'(bus.done), 64'h0);
    checkOutput("abort valM", bus.valM, 64'h0);
    checkOutput("abort dmem_error", 64'(bus.dmem_error), 64'h0);
    for (int i = 0; i < 4; i++) mMem[16'h200 + i] = 8'(8'h11 * (i + 1));
    mValM = 64'h0;
    mErr  = 1'b0;
    modelOp(4'h5, 64'h200, 64'h0, 64'h0, eM, eE, eL);
    applyStimulus("abort readback", 4'h5, 64'h200, 64'h0, 64'h0,
                  64'h1111111144332211, 1'b0, 9, 1'b0);

    // Randomized requests against the reference model
    $display("[TB] random run");
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: ic = 4'h1;
        1: ic = 4'h4;
        2: ic = 4'h5;
        3: ic = 4'h8;
        4: ic = 4'h9;
        5: ic = 4'hA;
        6: ic = 4'hB;
        default: ic = 4'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        addr = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(1017, 1023))
                                            : {$urandom, $urandom};
      end else begin
        addr = 64'($urandom_range(0, 1016));
      end
      other = {$urandom, $urandom};
      data  = {$urandom, $urandom};
      if ((ic == 4'h9) || (ic == 4'hB)) begin
        modelOp(ic, other, addr, data, eM, eE, eL);
        applyStimulus($sformatf("rand%0d", i), ic, other, addr, data,
                      eM, eE, eL, 1'($urandom_range(0, 1)));
      end else begin
        modelOp(ic, addr, data, other, eM, eE, eL);
        applyStimulus($sformatf("rand%0d", i), ic, addr, data, other,
                      eM, eE, eL, 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
